// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU core: bus widths, reset PC and instruction field layout.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 16;
  localparam int unsigned CPU_DATA_W  = 16;
  localparam int unsigned FETCH_DEPTH = 4;

  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'd10;

  // Opcode occupies the top bits of every instruction word.
  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = OPCODE_MSB - OPCODE_W + 1;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [CPU_DATA_W-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue: synchronous FIFO with flush; head data reads as zero when empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~flush_i & (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    rdata_o = '0;
    if (count_q != '0) rdata_o = mem_q[rd_ptr_q];
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited instruction memory requests, in-order prefetch queue,
// and redirect with discard of words still in flight from the abandoned stream.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned            ADDR_W   = CPU_ADDR_W,
  parameter int unsigned            DATA_W   = CPU_DATA_W,
  parameter int unsigned            DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_W-1:0]   inst_data,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic [OPCODE_W-1:0] opcode
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic [ENT_W-1:0]  q_wdata;
  logic [ENT_W-1:0]  q_rdata;

  logic              credit_ok;
  logic              issue;
  logic              rsp;

  // Queued plus outstanding words never exceed the queue depth, so a response always has room.
  always_comb begin
    credit_ok  = (SUM_W'(q_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    mem_req    = fetch_en & ~redirect_valid & credit_ok;
    mem_addr   = fetch_pc_q;
    issue      = mem_req & mem_gnt;
    rsp        = mem_rvalid & (inflight_q != '0);
    q_push     = rsp & ~redirect_valid & (discard_q == '0);
    inst_valid = ~q_empty & ~redirect_valid;
    q_pop      = inst_valid & inst_ready;
    q_wdata    = {resp_pc_q, mem_rdata};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(rsp);
    discard_d  = discard_q;
    if (rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    if (issue)  fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    if (q_push) resp_pc_d  = resp_pc_q + ADDR_W'(1);
    // Everything still outstanding after a redirect belongs to the abandoned stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_valid),
    .wdata_i (q_wdata),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    inst_pc   = q_rdata[ENT_W-1 -: ADDR_W];
    inst_data = q_rdata[DATA_W-1:0];
    opcode    = inst_data[OPCODE_MSB -: OPCODE_W];
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: in-order memory model plus a stream-level
// reference (expected next PC, live queue occupancy, epoch-tagged requests).
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic [2:0]  opcode;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'd10)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .opcode(opcode)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
    int          epoch;
    bit          orphan;
  } req_t;

  req_t        pend[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_pct = 100;
  int          epoch = 0;
  int          m_qcnt = 0;
  logic [15:0] m_next_addr = 16'd10;
  logic [15:0] m_exp_pc = 16'd10;
  bit          obs_valid;
  logic [15:0] obs_pc;
  logic [15:0] last_pop_pc = 16'h0;
  int          pops = 0;
  int          grants = 0;
  bit          saw_wrap = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'h0000_1234;
    return t[15:0] ^ t[31:16];
  endfunction

  function automatic int live_inflight();
    int n = 0;
    foreach (pend[i]) if (!pend[i].orphan) n++;
    return n;
  endfunction

  // One clock cycle: drive memory, check outputs against the stream model, advance the model.
  task automatic tick();
    bit          resp, push, pop, exp_req, exp_valid;
    logic [15:0] w;
    req_t        r;
    mem_gnt    = ($urandom_range(99) < gnt_pct);
    resp       = (pend.size() > 0) && (pend[0].due <= cyc);
    mem_rvalid = resp;
    mem_rdata  = resp ? mem_word(pend[0].addr) : 16'($urandom);
    #1;
    exp_req   = fetch_en && !redirect_valid && (m_qcnt + live_inflight() < DEPTH);
    exp_valid = (m_qcnt > 0) && !redirect_valid;
    n_cmp++;
    if (mem_req !== exp_req) begin
      n_err++; $display("FAIL mem_req cyc=%0d got %b expected %b", cyc, mem_req, exp_req);
    end
    if (exp_req) begin
      n_cmp++;
      if (mem_addr !== m_next_addr) begin
        n_err++; $display("FAIL mem_addr cyc=%0d got %h expected %h", cyc, mem_addr, m_next_addr);
      end
    end
    n_cmp++;
    if (inst_valid !== exp_valid) begin
      n_err++; $display("FAIL inst_valid cyc=%0d got %b expected %b", cyc, inst_valid, exp_valid);
    end
    if (m_qcnt > 0) begin
      w = mem_word(m_exp_pc);
      n_cmp++;
      if (inst_pc !== m_exp_pc || inst_data !== w || opcode !== w[15:13]) begin
        n_err++;
        $display("FAIL head cyc=%0d got pc=%h data=%h op=%0d expected pc=%h data=%h op=%0d",
                 cyc, inst_pc, inst_data, opcode, m_exp_pc, w, w[15:13]);
      end
    end else begin
      n_cmp++;
      if (inst_pc !== 16'h0 || inst_data !== 16'h0 || opcode !== 3'd0) begin
        n_err++;
        $display("FAIL empty_head cyc=%0d got pc=%h data=%h op=%0d expected zeros",
                 cyc, inst_pc, inst_data, opcode);
      end
    end
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    pop  = exp_valid && inst_ready;
    if (pop) begin
      if (last_pop_pc == 16'hFFFF && inst_pc == 16'h0000) saw_wrap = 1'b1;
      last_pop_pc = inst_pc;
      pops++;
    end
    push = 1'b0;
    if (resp) begin
      push = !pend[0].orphan && (pend[0].epoch == epoch) && !redirect_valid && rst_n;
      void'(pend.pop_front());
    end
    if (mem_req && mem_gnt && rst_n) begin
      r.addr = mem_addr; r.due = cyc + lat; r.epoch = epoch; r.orphan = 1'b0;
      pend.push_back(r);
      m_next_addr = m_next_addr + 16'd1;
      grants++;
    end
    if (push) m_qcnt++;
    if (pop) begin
      m_qcnt--;
      m_exp_pc = m_exp_pc + 16'd1;
    end
    if (redirect_valid) begin
      m_qcnt = 0;
      epoch++;
      m_next_addr = redirect_pc;
      m_exp_pc    = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit done = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (pend.size() == 0 && m_qcnt == 0) begin done = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL drain timeout got busy expected idle"); end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (obs_valid) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    inst_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got req=%b valid=%b expected 0 0", mem_req, inst_valid);
    end
    n_cmp++;
    if (inst_data !== 16'h0 || inst_pc !== 16'h0 || opcode !== 3'd0) begin
      n_err++; $display("FAIL reset_data got %h/%h/%0d expected zeros", inst_data, inst_pc, opcode);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream(input int l);
    int  first = -1;
    int  p0;
    logic [15:0] start_pc, first_pc = 16'h0;
    drain();
    lat = l; gnt_pct = 100; inst_ready = 1'b1; fetch_en = 1'b1;
    start_pc = m_exp_pc;
    p0 = pops;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_valid && first < 0) begin first = k; first_pc = obs_pc; end
    end
    n_cmp++;
    if (first !== l + 1) begin
      n_err++; $display("FAIL stream_latency lat=%0d got %0d expected %0d", l, first, l + 1);
    end
    n_cmp++;
    if (first_pc !== start_pc) begin
      n_err++; $display("FAIL stream_first_pc got %h expected %h", first_pc, start_pc);
    end
    n_cmp++;
    if (pops - p0 < 20) begin
      n_err++; $display("FAIL stream_throughput lat=%0d got %0d expected >=20", l, pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int g0, p0;
    drain();
    lat = 1; gnt_pct = 100; fetch_en = 1'b1; inst_ready = 1'b0;
    g0 = grants;
    repeat (20) tick();
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_stall got req=%b valid=%b expected 0 1", mem_req, inst_valid);
    end
    n_cmp++;
    if (grants - g0 !== DEPTH) begin
      n_err++; $display("FAIL bp_grants got %0d expected %0d", grants - g0, DEPTH);
    end
    inst_ready = 1'b1;
    p0 = pops;
    repeat (20) tick();
    n_cmp++;
    if (pops - p0 < 15) begin
      n_err++; $display("FAIL bp_release got %0d pops expected >=15", pops - p0);
    end
  endtask

  task automatic test_redirect_flush();
    bit seen, armed = 1'b0;
    drain();
    lat = 3; gnt_pct = 100; inst_ready = 1'b1; fetch_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (live_inflight() == 3) begin armed = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!armed) begin n_err++; $display("FAIL redir_setup got not armed expected 3 in flight"); end
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    wait_valid(seen);
    n_cmp++;
    if (!seen || obs_pc !== 16'h0040) begin
      n_err++; $display("FAIL redir_target got seen=%b pc=%h expected 1 0040", seen, obs_pc);
    end
  endtask

  task automatic test_redirect_collide();
    bit seen, armed = 1'b0;
    drain();
    lat = 1; gnt_pct = 100; inst_ready = 1'b1; fetch_en = 1'b1;
    repeat (6) tick();
    for (int k = 0; k < 20; k++) begin
      if (m_qcnt > 0 && pend.size() > 0 && pend[0].due <= cyc) begin armed = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!armed) begin n_err++; $display("FAIL collide_setup got not armed expected rvalid+pop"); end
    redirect_valid = 1'b1; redirect_pc = 16'h2468;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0) begin
      n_err++; $display("FAIL collide_empty got valid=%b expected 0", obs_valid);
    end
    wait_valid(seen);
    n_cmp++;
    if (!seen || obs_pc !== 16'h2468) begin
      n_err++; $display("FAIL collide_target got seen=%b pc=%h expected 1 2468", seen, obs_pc);
    end
  endtask

  task automatic test_gnt_stall_wrap();
    drain();
    lat = 2; gnt_pct = 0; inst_ready = 1'b1; fetch_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 16'hFFFE) begin
        n_err++; $display("FAIL gnt_hold k=%0d got req=%b addr=%h expected 1 fffe", k, mem_req, mem_addr);
      end
      tick();
    end
    gnt_pct = 100;
    saw_wrap = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (saw_wrap !== 1'b1) begin
      n_err++; $display("FAIL pc_wrap got %b expected 1 (ffff then 0000)", saw_wrap);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, armed = 1'b0;
    drain();
    lat = 3; gnt_pct = 100; inst_ready = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (m_qcnt == 2 && live_inflight() == 2) begin armed = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!armed) begin n_err++; $display("FAIL rst_setup got not armed expected 2+2"); end
    fetch_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 16'h0 ||
        inst_pc !== 16'h0 || opcode !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid got req=%b valid=%b data=%h pc=%h op=%0d expected zeros",
               mem_req, inst_valid, inst_data, inst_pc, opcode);
    end
    foreach (pend[i]) pend[i].orphan = 1'b1;
    m_qcnt = 0; epoch++;
    m_next_addr = 16'd10; m_exp_pc = 16'd10;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10 && pend.size() > 0; k++) tick();
    tick();
    fetch_en = 1'b1; inst_ready = 1'b1;
    wait_valid(seen);
    n_cmp++;
    if (!seen || obs_pc !== 16'd10) begin
      n_err++; $display("FAIL rst_restart got seen=%b pc=%h expected 1 000a", seen, obs_pc);
    end
  endtask

  task automatic test_random();
    for (int l = 1; l <= 3; l++) begin
      drain();
      lat = l;
      for (int k = 0; k < 300; k++) begin
        fetch_en       = ($urandom_range(99) < 80);
        inst_ready     = ($urandom_range(99) < 70);
        redirect_valid = ($urandom_range(99) < 5);
        redirect_pc    = 16'($urandom);
        gnt_pct        = 70;
        tick();
      end
      redirect_valid = 1'b0;
      gnt_pct = 100;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream(1);
    test_stream(3);
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_gnt_stall_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
